// File: rtl/reg_read_port_pkg.sv
// Shared constants for the register read port: address widths, bank encoding and data width.
package reg_read_port_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned ROM_ADDR_W = 3;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic {
    BANK_GEN = 1'b0,
    BANK_ROM = 1'b1
  } bank_e;

endpackage

// File: rtl/reg_bank.sv
// Register storage array: one synchronous write port and two combinational read ports.
module reg_bank #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_a_i,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [Width-1:0] rdata_a_o,
  output logic [Width-1:0] rdata_b_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/reg_read_port.sv
// Dual-bank register file with two registered read ports, write-to-read bypass and stall hold.
module reg_read_port
  import reg_read_port_pkg::*;
#(
  parameter int unsigned DATA_W       = reg_read_port_pkg::DATA_W,
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned NUM_ROM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  romRegWrite_flag,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     output_Data,
  input  logic [DATA_W-1:0]     romoutput_Data,
  input  logic                  rd_valid,
  input  logic                  rd_rom_sel,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  input  logic                  stall,
  output logic [DATA_W-1:0]     data_a,
  output logic [DATA_W-1:0]     data_b,
  output logic                  data_valid,
  output logic                  addr_err
);

  localparam logic [REG_ADDR_W-1:0] RomLimit = REG_ADDR_W'(NUM_ROM_REGS);

  bank_e wr_bank, rd_bank;
  logic  wr_oob, gen_we, rom_we, wr_commit;
  logic  rd_accept, rd_oob_a, rd_oob_b;
  logic  byp_a, byp_b;

  logic [DATA_W-1:0] gen_rdata_a, gen_rdata_b, rom_rdata_a, rom_rdata_b;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic              data_valid_q, data_valid_d;
  logic              addr_err_q, addr_err_d;

  assign wr_bank   = romRegWrite_flag ? BANK_ROM : BANK_GEN;
  assign rd_bank   = rd_rom_sel ? BANK_ROM : BANK_GEN;
  assign wr_oob    = wr_en && (wr_bank == BANK_ROM) && (wr_addr >= RomLimit);
  assign gen_we    = wr_en && (wr_bank == BANK_GEN);
  assign rom_we    = wr_en && (wr_bank == BANK_ROM) && !wr_oob;
  assign wr_commit = gen_we || rom_we;
  assign wr_data   = (wr_bank == BANK_ROM) ? romoutput_Data : output_Data;

  assign rd_accept = rd_valid && !stall;
  assign rd_oob_a  = (rd_bank == BANK_ROM) && (rd_addr_a >= RomLimit);
  assign rd_oob_b  = (rd_bank == BANK_ROM) && (rd_addr_b >= RomLimit);

  // Dropped out-of-range ROM writes never commit, so they never bypass.
  assign byp_a = wr_commit && (wr_bank == rd_bank) && (wr_addr == rd_addr_a);
  assign byp_b = wr_commit && (wr_bank == rd_bank) && (wr_addr == rd_addr_b);

  reg_bank #(
    .Width(DATA_W),
    .Depth(NUM_REGS),
    .AddrW(REG_ADDR_W)
  ) u_gen_bank (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (gen_we),
    .waddr_i  (wr_addr),
    .wdata_i  (output_Data),
    .raddr_a_i(rd_addr_a),
    .raddr_b_i(rd_addr_b),
    .rdata_a_o(gen_rdata_a),
    .rdata_b_o(gen_rdata_b)
  );

  reg_bank #(
    .Width(DATA_W),
    .Depth(NUM_ROM_REGS),
    .AddrW(ROM_ADDR_W)
  ) u_rom_bank (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (rom_we),
    .waddr_i  (wr_addr[ROM_ADDR_W-1:0]),
    .wdata_i  (romoutput_Data),
    .raddr_a_i(rd_addr_a[ROM_ADDR_W-1:0]),
    .raddr_b_i(rd_addr_b[ROM_ADDR_W-1:0]),
    .rdata_a_o(rom_rdata_a),
    .rdata_b_o(rom_rdata_b)
  );

  always_comb begin
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    data_valid_d = data_valid_q;
    addr_err_d   = addr_err_q;

    if (!stall) begin
      data_valid_d = rd_valid;
      if (rd_accept || wr_en) begin
        addr_err_d = wr_oob || (rd_accept && (rd_oob_a || rd_oob_b));
      end
    end

    if (rd_accept) begin
      if (rd_oob_a) begin
        data_a_d = '0;
      end else if (byp_a) begin
        data_a_d = wr_data;
      end else begin
        data_a_d = (rd_bank == BANK_ROM) ? rom_rdata_a : gen_rdata_a;
      end

      if (rd_oob_b) begin
        data_b_d = '0;
      end else if (byp_b) begin
        data_b_d = wr_data;
      end else begin
        data_b_d = (rd_bank == BANK_ROM) ? rom_rdata_b : gen_rdata_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a_q     <= '0;
      data_b_q     <= '0;
      data_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      data_valid_q <= data_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign data_a     = data_a_q;
  assign data_b     = data_b_q;
  assign data_valid = data_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: doc/reg_read_port.md
# reg_read_port

Dual-bank register file with two registered read ports, the read-side counterpart of the writeback stage.
- Writes: holds the 16 general registers and the 8 microcode (ROM-path) registers, written from writeback's `output_Data` / `romoutput_Data`.
- Reads: supplies operand A and operand B to the ALU/mov path; operand B also drives writeback's `reg_in`.
- Timing: registered one-cycle read latency, stall hold, and write-to-read bypass. A read issued in the same cycle as a writeback sees the written value.

## Interface
- `DATA_W`, 32, register width
- `NUM_REGS`, 16, general register count (address width 4)
- `NUM_ROM_REGS`, 8, microcode register count (address width 3)

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  write strobe from writeback
- `romRegWrite_flag`  in  1  1 = write targets the ROM bank with `romoutput_Data`; 0 = general bank with `output_Data`
- `wr_addr`  in  4  destination register
- `output_Data`  in  DATA_W  general-bank write data
- `romoutput_Data`  in  DATA_W  ROM-bank write data
- `rd_valid`  in  1  read request
- `rd_rom_sel`  in  1  1 = both reads address the ROM bank
- `rd_addr_a`, `rd_addr_b`  in  4  read addresses
- `stall`  in  1  hold all read outputs
- `data_a`, `data_b`  out  DATA_W  registered operands
- `data_valid`  out  1  `data_a`/`data_b` correspond to an accepted request
- `addr_err`  out  1  registered; last accepted read or write used a ROM-bank address ≥ `NUM_ROM_REGS`

## Operation
- Reset: all 24 registers = 0, `data_a` = `data_b` = 0, `data_valid` = 0, `addr_err` = 0.
  - Reset overrides write, read and stall in the same cycle.
- Write: at `wr_en` = 1, the selected bank entry takes its data on the edge.
  - ROM bank uses `wr_addr[2:0]`.
  - If `wr_addr[3]` = 1 with `romRegWrite_flag` = 1, the write is dropped and `addr_err` = 1.
- Read acceptance: a read is accepted when `rd_valid` = 1 and `stall` = 0.
  - On acceptance, `data_a`/`data_b` load the addressed entries and `data_valid` = 1.
  - ROM-bank reads with address bit 3 set return 0 and set `addr_err`.
- Bypass: an accepted read and a `wr_en` write in the same cycle, with matching bank and address, returns the new write data, not the stale entry. This applies independently per port.
- Bubble: `rd_valid` = 0 with `stall` = 0 gives `data_valid` = 0 next cycle. `data_a`/`data_b` keep their last values.
- Stall: `stall` = 1 freezes `data_a`, `data_b`, `data_valid` and `addr_err`. Writes still commit during stall.
- `addr_err` update: on each cycle that has an accepted read or a write, `addr_err` is re-evaluated and is the OR of both conditions. Otherwise it holds.

## Timing
- Read latency: request in cycle N gives operands valid after edge N+1.
  - There is no combinational path from read address to output.
- Write visibility: a write at edge N is readable by a request in cycle N (bypass) or any later cycle.
- Throughput: one read pair per cycle, plus one write per cycle, concurrently.
- Simultaneous `wr_en` and `rst`: reset wins and the register stays 0.
- Stall released: the next cycle's request is accepted normally. No request is lost or replayed; the upstream block holds `rd_valid` and the addresses while `stall` = 1.

## Structure
- A shared SCC package holds:
  - `REG_ADDR_W` = 4 and `ROM_ADDR_W` = 3
  - the bank-select encoding (`BANK_GEN` = 0, `BANK_ROM` = 1)
  - `DATA_W`
- Sub-module `reg_bank`: parameterised storage array with one write port and two combinational reads, instantiated twice (16 and 8 entries).
- The top level holds bank muxing, bypass comparators, output registers, and the stall/valid/error logic.

## Test plan
- Reset: write `0xDEADBEEF` to r3, then pulse `rst`, then read r3 → `data_a` = 0, `data_valid` = 0 during reset and = 1 one cycle after the read.
- Basic: write r5 = `0x12345678`, ROM r5 = `0xCAFE0000`. Read A = r5 with `rd_rom_sel` = 0, then with 1 → `0x12345678`, then `0xCAFE0000`.
- Bypass: in the same cycle, write r7 = `0x0000AAAA` and read A = r7, B = r7 → both `0x0000AAAA` next cycle. A ROM write to address 7 in the same cycle does not affect a general-bank read of r7.
- Stall: read r1 = `0x11`; hold `stall` = 1 for 3 cycles while writing r1 = `0x22` → outputs stay `0x11`. After release, a read of r1 → `0x22`.
- ROM range: ROM write to address 9 → `addr_err` = 1 and no ROM register changes. ROM read of address 12 → `data_a` = 0 and `addr_err` = 1.
- Back-to-back: read r0..r15 on consecutive cycles with `data_b` = r(15−i) → `data_valid` stays 1 and every value matches the preloaded pattern `i × 0x01010101`.
